// File: rtl/alu_mc_if.sv
// Request/result handshake bundle between the register-read stage and alu_mc.
// master drives operations and consumes results; slave is the ALU side.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       control_in;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, control_in, in1, in2, out_ready,
        input  in_ready, out_valid, out, zero, ovf
    );

    modport slave (
        input  in_valid, control_in, in1, in2, out_ready,
        output in_ready, out_valid, out, zero, ovf
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU: 1 cycle for simple ops, amount+1 for shifts, WIDTH+1 for MUL.
// Result is held in DONE until out_ready; in_ready is high only in IDLE.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic   clk,
    input  logic   rst_n,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b1101;
    localparam logic [3:0] OP_SRL = 4'b1110;
    localparam logic [3:0] OP_SRA = 4'b1111;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [3:0]       op;
    logic [WIDTH-1:0] acc, mcand, mplier;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] res;
    logic             res_zero, res_ovf, res_valid;

    logic [WIDTH-1:0] sum, diff, imm_res, step_acc;
    logic             imm_ovf, is_shift, go_busy;
    logic [SHW-1:0]   amt;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = res_valid;
    assign bus.out       = res;
    assign bus.zero      = res_zero;
    assign bus.ovf       = res_ovf;

    assign amt = bus.in2[SHW-1:0];

    always_comb begin
        sum      = bus.in1 + bus.in2;
        diff     = bus.in1 - bus.in2;
        imm_res  = '0;
        imm_ovf  = 1'b0;
        is_shift = (bus.control_in == OP_SLL) || (bus.control_in == OP_SRL) ||
                   (bus.control_in == OP_SRA);
        go_busy  = (bus.control_in == OP_MUL) || (is_shift && (amt != '0));
        case (bus.control_in)
            4'b0000, 4'b0001, 4'b0010, 4'b0011: begin
                imm_res = sum;
                imm_ovf = (bus.in1[WIDTH-1] == bus.in2[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            4'b0101, 4'b0110: imm_res = bus.in1 & bus.in2;
            4'b0111:          imm_res = ~(bus.in1 | bus.in2);
            4'b1000: begin
                imm_res = diff;
                imm_ovf = (bus.in1[WIDTH-1] != bus.in2[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.in1[WIDTH-1]);
            end
            // Zero-amount shifts land here as well as PASS.
            4'b1001, 4'b1010, OP_SLL, OP_SRL, OP_SRA: imm_res = bus.in1;
            4'b1011: imm_res = WIDTH'($signed(bus.in1) < $signed(bus.in2));
            4'b1100: imm_res = WIDTH'(bus.in1 < bus.in2);
            default: imm_res = '0;
        endcase
    end

    always_comb begin
        step_acc = acc;
        case (op)
            OP_SLL:  step_acc = acc << 1;
            OP_SRL:  step_acc = acc >> 1;
            OP_SRA:  step_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_MUL:  step_acc = mplier[0] ? acc + mcand : acc;
            default: step_acc = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            op        <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            res       <= '0;
            res_zero  <= 1'b0;
            res_ovf   <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    op <= bus.control_in;
                    if (go_busy) begin
                        state  <= BUSY;
                        acc    <= (bus.control_in == OP_MUL) ? '0 : bus.in1;
                        mcand  <= bus.in1;
                        mplier <= bus.in2;
                        cnt    <= (bus.control_in == OP_MUL) ? CNT_MUL : {1'b0, amt};
                    end else begin
                        state     <= DONE;
                        res       <= imm_res;
                        res_zero  <= (imm_res == '0);
                        res_ovf   <= imm_ovf;
                        res_valid <= 1'b1;
                    end
                end
                BUSY: begin
                    acc    <= step_acc;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state     <= DONE;
                        res       <= step_acc;
                        res_zero  <= (step_acc == '0);
                        res_ovf   <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) begin
                    state     <= IDLE;
                    res_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
